// File: rtl/sonar_ping_sequencer.sv
// Wishbone-configured sonar ping sequencer: TX burst, blanking, listen window, TOF capture, IRQ.
// Optional macro SONAR_SEQ_ECHO_SYNC_EN adds a 2-flop synchronizer on echo_i (TOF reads 2 higher).
`timescale 1ns/1ps
`default_nettype none

module sonar_ping_sequencer #(
    parameter logic [31:0] BASE_ADDR = 32'h3000_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic        wbs_cyc_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_adr_i,
    input  logic [31:0] wbs_dat_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o,
    input  logic        echo_i,
    output logic        tx_o,
    output logic        rx_en_o,
    output logic        busy_o,
    output logic        irq_o
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TX     = 3'd1,
        S_BLANK  = 3'd2,
        S_LISTEN = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic        r_ack;
    logic [31:0] r_dat;
    logic        r_start_p;
    logic        r_abort_p;

    logic        r_cont;
    logic        r_irq_en;
    logic [15:0] r_tx_len;
    logic [7:0]  r_tx_div;
    logic [15:0] r_blank;
    logic [15:0] r_window;

    logic [15:0] r_tof;
    logic        r_valid;
    logic        r_timeout;
    logic        r_irq_flag;

    logic [15:0] r_l_tx_len_m1;
    logic [7:0]  r_l_tx_div;
    logic [15:0] r_l_blank;
    logic [15:0] r_l_win_m1;

    logic [15:0] r_cnt;
    logic [7:0]  r_div_cnt;
    logic        r_tx;

    logic        w_hit;
    logic        w_req;
    logic        w_wr;
    logic [1:0]  w_idx;
    logic        w_ctrl_wr;
    logic        w_w1c_valid;
    logic        w_w1c_timeout;
    logic [31:0] w_rd_data;
    logic        w_busy;
    logic        w_echo;
    logic        w_echo_hit;
    logic        w_win_end;
    logic        w_enter_tx;
    logic [15:0] w_tx_len_m1;
    logic [15:0] w_win_m1;
    logic        w_unused_adr;

    assign w_unused_adr = ^wbs_adr_i[1:0];

    // ---------------- Wishbone decode ----------------
    assign w_hit         = (wbs_adr_i[31:4] == BASE_ADDR[31:4]);
    assign w_req         = wbs_cyc_i & wbs_stb_i & w_hit & ~r_ack;
    assign w_wr          = w_req & wbs_we_i;
    assign w_idx         = wbs_adr_i[3:2];
    assign w_ctrl_wr     = w_wr && (w_idx == 2'd0) && wbs_sel_i[0];
    assign w_w1c_valid   = w_wr && (w_idx == 2'd3) && wbs_sel_i[2] && wbs_dat_i[16];
    assign w_w1c_timeout = w_wr && (w_idx == 2'd3) && wbs_sel_i[2] && wbs_dat_i[17];
    assign w_busy        = (r_state != S_IDLE);

    always_comb begin
        w_rd_data = 32'h0;
        case (w_idx)
            2'd0:    w_rd_data = {28'h0, 1'b0, r_irq_en, r_cont, 1'b0};
            2'd1:    w_rd_data = {8'h0, r_tx_div, r_tx_len};
            2'd2:    w_rd_data = {r_window, r_blank};
            default: w_rd_data = {13'h0, w_busy, r_timeout, r_valid, r_tof};
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_ack     <= 1'b0;
            r_dat     <= 32'h0;
            r_start_p <= 1'b0;
            r_abort_p <= 1'b0;
        end else begin
            r_ack     <= w_req;
            r_dat     <= (w_req && !wbs_we_i) ? w_rd_data : 32'h0;
            // START/ABORT become one-cycle pulses so the FSM reacts on the edge after the ack
            r_start_p <= w_ctrl_wr & wbs_dat_i[0];
            r_abort_p <= w_ctrl_wr & wbs_dat_i[3];
        end
    end

    assign wbs_ack_o = r_ack;
    assign wbs_dat_o = r_dat;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cont   <= 1'b0;
            r_irq_en <= 1'b0;
            r_tx_len <= 16'h0;
            r_tx_div <= 8'h0;
            r_blank  <= 16'h0;
            r_window <= 16'h0;
        end else if (w_wr) begin
            case (w_idx)
                2'd0: begin
                    if (wbs_sel_i[0]) begin
                        r_cont   <= wbs_dat_i[1];
                        r_irq_en <= wbs_dat_i[2];
                    end
                end
                2'd1: begin
                    if (wbs_sel_i[0]) r_tx_len[7:0]  <= wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) r_tx_len[15:8] <= wbs_dat_i[15:8];
                    if (wbs_sel_i[2]) r_tx_div       <= wbs_dat_i[23:16];
                end
                2'd2: begin
                    if (wbs_sel_i[0]) r_blank[7:0]   <= wbs_dat_i[7:0];
                    if (wbs_sel_i[1]) r_blank[15:8]  <= wbs_dat_i[15:8];
                    if (wbs_sel_i[2]) r_window[7:0]  <= wbs_dat_i[23:16];
                    if (wbs_sel_i[3]) r_window[15:8] <= wbs_dat_i[31:24];
                end
                default: ;
            endcase
        end
    end

    // ---------------- Echo input ----------------
`ifdef SONAR_SEQ_ECHO_SYNC_EN
    logic r_echo_s1;
    logic r_echo_s2;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_echo_s1 <= 1'b0;
            r_echo_s2 <= 1'b0;
        end else begin
            r_echo_s1 <= echo_i;
            r_echo_s2 <= r_echo_s1;
        end
    end

    assign w_echo = r_echo_s2;
`else
    assign w_echo = echo_i;
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) r_state <= S_IDLE;
        else            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_echo_hit   = 1'b0;
        w_win_end    = 1'b0;
        tx_o         = 1'b0;
        rx_en_o      = 1'b0;
        busy_o       = w_busy;
        if (r_abort_p) begin
            w_state_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (r_start_p) w_state_next = S_TX;
                end
                S_TX: begin
                    if (r_cnt == r_l_tx_len_m1)
                        w_state_next = (r_l_blank == 16'h0) ? S_LISTEN : S_BLANK;
                end
                S_BLANK: begin
                    if (r_cnt == r_l_blank - 16'd1) w_state_next = S_LISTEN;
                end
                S_LISTEN: begin
                    if (w_echo) begin
                        w_echo_hit   = 1'b1;
                        w_state_next = S_DONE;
                    end else if (r_cnt == r_l_win_m1) begin
                        w_win_end    = 1'b1;
                        w_state_next = S_DONE;
                    end
                end
                S_DONE: begin
                    w_state_next = r_cont ? S_TX : S_IDLE;
                end
                default: w_state_next = S_IDLE;
            endcase
        end
        tx_o    = (r_state == S_TX) & r_tx;
        rx_en_o = (r_state == S_LISTEN);
    end

    // ---------------- Phase counters and TX waveform ----------------
    assign w_enter_tx  = (w_state_next == S_TX) && (r_state != S_TX);
    assign w_tx_len_m1 = (r_tx_len == 16'h0) ? 16'h0 : r_tx_len - 16'd1;
    assign w_win_m1    = (r_window == 16'h0) ? 16'h0 : r_window - 16'd1;

    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_cnt         <= 16'h0;
            r_div_cnt     <= 8'h0;
            r_tx          <= 1'b0;
            r_l_tx_len_m1 <= 16'h0;
            r_l_tx_div    <= 8'h0;
            r_l_blank     <= 16'h0;
            r_l_win_m1    <= 16'h0;
        end else begin
            if (r_state == S_IDLE || w_state_next != r_state) r_cnt <= 16'h0;
            else                                              r_cnt <= r_cnt + 16'd1;

            if (w_enter_tx) begin
                // Snapshot of the configuration; later writes only affect the next ping
                r_l_tx_len_m1 <= w_tx_len_m1;
                r_l_tx_div    <= r_tx_div;
                r_l_blank     <= r_blank;
                r_l_win_m1    <= w_win_m1;
                r_tx          <= 1'b1;
                r_div_cnt     <= 8'h0;
            end else if (r_state == S_TX) begin
                if (r_div_cnt == r_l_tx_div) begin
                    r_div_cnt <= 8'h0;
                    r_tx      <= ~r_tx;
                end else begin
                    r_div_cnt <= r_div_cnt + 8'd1;
                end
            end else begin
                r_tx      <= 1'b0;
                r_div_cnt <= 8'h0;
            end
        end
    end

    // ---------------- Status and interrupt ----------------
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            r_tof      <= 16'h0;
            r_valid    <= 1'b0;
            r_timeout  <= 1'b0;
            r_irq_flag <= 1'b0;
        end else begin
            if (w_echo_hit) begin
                r_tof     <= r_cnt;
                r_valid   <= 1'b1;
                r_timeout <= 1'b0;
            end else if (w_win_end) begin
                r_tof     <= 16'hFFFF;
                r_timeout <= 1'b1;
                r_valid   <= 1'b0;
            end else begin
                if (w_w1c_valid)   r_valid   <= 1'b0;
                if (w_w1c_timeout) r_timeout <= 1'b0;
            end

            // A hardware set in the same cycle as a software clear keeps the flag
            if (r_state == S_DONE && r_irq_en)        r_irq_flag <= 1'b1;
            else if (w_w1c_valid || w_w1c_timeout)    r_irq_flag <= 1'b0;
        end
    end

    assign irq_o = r_irq_flag & r_irq_en;

endmodule

`default_nettype wire

// File: tb/tb_sonar_ping_sequencer.sv
// Directed self-checking bench for sonar_ping_sequencer; expected values are hand-computed.
`timescale 1ns/1ps

module tb_sonar_ping_sequencer;

    localparam logic [31:0] BASE = 32'h3000_0000;
`ifdef SONAR_SEQ_ECHO_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    // ping length with TX_LEN=8, BLANK=4, echo at listen cycle 3
    localparam int P_CONT = 8 + 4 + (3 + SYNC_LAT + 1) + 1;

    logic        clk;
    logic        rst_n;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] wdat;
    logic        ack;
    logic [31:0] rdat;
    logic        echo;
    logic        tx;
    logic        rx_en;
    logic        busy;
    logic        irq;

    int n_checks = 0;
    int n_errors = 0;

    sonar_ping_sequencer #(.BASE_ADDR(BASE)) dut (
        .wb_clk_i  (clk),
        .wb_rst_ni (rst_n),
        .wbs_cyc_i (cyc),
        .wbs_stb_i (stb),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_adr_i (adr),
        .wbs_dat_i (wdat),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat),
        .echo_i    (echo),
        .tx_o      (tx),
        .rx_en_o   (rx_en),
        .busy_o    (busy),
        .irq_o     (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic wb_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic got;
        got  = 1'b0;
        adr  = BASE + a;
        wdat = d;
        sel  = s;
        we   = 1'b1;
        cyc  = 1'b1;
        stb  = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) got = 1'b1;
        end
        cyc = 1'b0;
        stb = 1'b0;
        we  = 1'b0;
        chk($sformatf("wr_ack_%0h", a), {31'h0, got}, 32'h1);
    endtask

    task automatic wb_read(input logic [31:0] a, output logic [31:0] d);
        logic got;
        got = 1'b0;
        d   = 32'hDEAD_BEEF;
        adr = BASE + a;
        sel = 4'hF;
        we  = 1'b0;
        cyc = 1'b1;
        stb = 1'b1;
        for (int i = 0; i < 4 && !got; i++) begin
            @(negedge clk);
            if (ack) begin
                got = 1'b1;
                d   = rdat;
            end
        end
        cyc = 1'b0;
        stb = 1'b0;
        chk($sformatf("rd_ack_%0h", a), {31'h0, got}, 32'h1);
    endtask

    // Follows one ping from the cycle before TX until the first idle cycle.
    task automatic run_ping(input int echo_at, output int n_rx, output int n_busy,
                            output logic [15:0] txb);
        logic seen;
        seen   = 1'b0;
        n_rx   = 0;
        n_busy = 0;
        txb    = '0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (busy) begin
                n_busy++;
                seen = 1'b1;
                if (n_busy <= 16) txb[n_busy-1] = tx;
            end else if (seen) begin
                break;
            end
            if (rx_en) begin
                n_rx++;
                if (n_rx == echo_at + 1) echo = 1'b1;
            end else begin
                echo = 1'b0;
            end
        end
        echo = 1'b0;
    endtask

    initial begin
        int          n_rx;
        int          n_busy;
        int          n_pings;
        int          n_ack;
        int          lrx;
        logic        seen;
        logic        ack_c;
        logic [15:0] txb;
        logic [31:0] d;

        rst_n = 1'b0;
        cyc   = 1'b0;
        stb   = 1'b0;
        we    = 1'b0;
        sel   = 4'h0;
        adr   = 32'h0;
        wdat  = 32'h0;
        echo  = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'h0, tx}, 32'h0);
        chk("rst_rx_en", {31'h0, rx_en}, 32'h0);
        chk("rst_busy", {31'h0, busy}, 32'h0);
        chk("rst_irq", {31'h0, irq}, 32'h0);
        chk("rst_ack", {31'h0, ack}, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            wb_read(r * 4, d);
            chk($sformatf("rst_reg%0d", r), d, 32'h0);
        end
        @(negedge clk);
        chk("dat_idle_zero", rdat, 32'h0);

        // Ping 1: echo 10 cycles into LISTEN
        wb_write(32'h4, 32'h0001_0008, 4'hF);
        wb_write(32'h8, 32'h0064_0004, 4'hF);
        wb_read(32'h4, d);
        chk("pulse_rb", d, 32'h0001_0008);
        wb_read(32'h8, d);
        chk("timing_rb", d, 32'h0064_0004);
        wb_write(32'h0, 32'h0000_0005, 4'hF);
        run_ping(10, n_rx, n_busy, txb);
        chk("p1_tx_pattern", {16'h0, txb}, 32'h0000_0033);
        chk("p1_rx_cycles", n_rx, 11 + SYNC_LAT);
        chk("p1_ping_len", n_busy, 8 + 4 + 11 + SYNC_LAT + 1);
        chk("p1_irq", {31'h0, irq}, 32'h1);
        chk("p1_busy_off", {31'h0, busy}, 32'h0);
        wb_read(32'hC, d);
        chk("p1_status", d, 32'h0001_0000 | (10 + SYNC_LAT));
        wb_read(32'h0, d);
        chk("ctrl_rb", d, 32'h0000_0004);
        repeat (3) @(negedge clk);
        chk("p1_irq_hold", {31'h0, irq}, 32'h1);
        wb_write(32'hC, 32'h0001_0000, 4'hF);
        chk("p1_irq_clr", {31'h0, irq}, 32'h0);
        wb_read(32'hC, d);
        chk("p1_status_clr", d, 32'(10 + SYNC_LAT));

        // Ping 2: WINDOW=20, no echo
        wb_write(32'h8, 32'h0014_0004, 4'hF);
        wb_write(32'h0, 32'h0000_0005, 4'hF);
        run_ping(-1, n_rx, n_busy, txb);
        chk("p2_rx_cycles", n_rx, 20);
        chk("p2_ping_len", n_busy, 8 + 4 + 20 + 1);
        chk("p2_irq", {31'h0, irq}, 32'h1);
        wb_read(32'hC, d);
        chk("p2_status", d, 32'h0002_FFFF);
        wb_write(32'hC, 32'h0002_0000, 4'hF);
        chk("p2_irq_clr", {31'h0, irq}, 32'h0);
        wb_read(32'hC, d);
        chk("p2_status_clr", d, 32'h0000_FFFF);

        // Continuous mode: three pings, CONT cleared during the third TX
        wb_write(32'h8, 32'h0064_0004, 4'hF);
        wb_write(32'h0, 32'h0000_0007, 4'hF);
        n_busy  = 0;
        n_pings = 0;
        lrx     = 0;
        seen    = 1'b0;
        ack_c   = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (cyc) begin
                ack_c = ack;
                cyc   = 1'b0;
                stb   = 1'b0;
                we    = 1'b0;
            end
            if (busy) begin
                n_busy++;
                seen = 1'b1;
            end else if (seen) begin
                break;
            end
            if (rx_en) begin
                if (lrx == 0) n_pings++;
                lrx++;
                if (lrx == 4) echo = 1'b1;
            end else begin
                lrx  = 0;
                echo = 1'b0;
            end
            if (n_busy == 2 * P_CONT + 3) begin
                adr  = BASE;
                wdat = 32'h0000_0004;
                sel  = 4'hF;
                we   = 1'b1;
                cyc  = 1'b1;
                stb  = 1'b1;
            end
        end
        echo = 1'b0;
        chk("c_ack", {31'h0, ack_c}, 32'h1);
        chk("c_pings", n_pings, 3);
        chk("c_busy_len", n_busy, 3 * P_CONT);
        chk("c_irq", {31'h0, irq}, 32'h1);
        wb_read(32'hC, d);
        chk("c_status", d, 32'h0001_0000 | (3 + SYNC_LAT));
        wb_read(32'h0, d);
        chk("c_ctrl_rb", d, 32'h0000_0004);
        wb_write(32'hC, 32'h0001_0000, 4'hF);
        chk("c_irq_clr", {31'h0, irq}, 32'h0);

        // ABORT during BLANK
        wb_write(32'h8, 32'h0064_0014, 4'hF);
        wb_write(32'h0, 32'h0000_0005, 4'hF);
        repeat (11) @(negedge clk);
        chk("d_busy_blank", {31'h0, busy}, 32'h1);
        chk("d_tx_blank", {31'h0, tx}, 32'h0);
        wb_write(32'h0, 32'h0000_000C, 4'hF);
        @(negedge clk);
        chk("d_busy_abort", {31'h0, busy}, 32'h0);
        chk("d_tx_abort", {31'h0, tx}, 32'h0);
        chk("d_rx_abort", {31'h0, rx_en}, 32'h0);
        chk("d_irq_abort", {31'h0, irq}, 32'h0);
        wb_read(32'hC, d);
        chk("d_status_kept", d, 32'(3 + SYNC_LAT));
        wb_read(32'h0, d);
        chk("d_ctrl_rb", d, 32'h0000_0004);

        // ABORT during TX forces tx_o low
        wb_write(32'h0, 32'h0000_0005, 4'hF);
        @(negedge clk);
        chk("e_tx_on", {31'h0, tx}, 32'h1);
        wb_write(32'h0, 32'h0000_000C, 4'hF);
        @(negedge clk);
        chk("e_tx_off", {31'h0, tx}, 32'h0);
        chk("e_busy_off", {31'h0, busy}, 32'h0);

        // START together with ABORT stays idle
        wb_write(32'h0, 32'h0000_000D, 4'hF);
        repeat (2) @(negedge clk);
        chk("f_busy", {31'h0, busy}, 32'h0);
        chk("f_tx", {31'h0, tx}, 32'h0);

        // Byte-select write: only TX_DIV lane updates
        wb_write(32'h4, 32'hAABB_CCDD, 4'b0100);
        wb_read(32'h4, d);
        chk("g_pulse_sel", d, 32'h00BB_0008);

        // Held strobe acks every other cycle
        adr   = BASE + 32'hC;
        we    = 1'b0;
        sel   = 4'hF;
        cyc   = 1'b1;
        stb   = 1'b1;
        n_ack = 0;
        repeat (4) begin
            @(negedge clk);
            if (ack) n_ack++;
        end
        cyc = 1'b0;
        stb = 1'b0;
        chk("h_b2b_acks", n_ack, 2);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/sonar_ping_sequencer.md
# sonar_ping_sequencer

Wishbone-configured sequencer that runs one sonar measurement ("ping") end to end: transmit burst, receiver blanking, listen window, time-of-flight capture, interrupt. It sits inside the SonarOnChip user project on the management-SoC Wishbone slave bus. It drives the transducer TX pad and the receive-chain enable, and takes a single-bit echo-detect flag from the receive datapath.

## Interface
- `BASE_ADDR`, default 32'h3000_0000: block decodes when `wbs_adr_i[31:4] == BASE_ADDR[31:4]`.
- `wb_clk_i`  in  1  sole clock.
- `wb_rst_ni`  in  1  asynchronous active-low reset.
- `wbs_cyc_i`, `wbs_stb_i`, `wbs_we_i`  in  1 each  Wishbone classic cycle/strobe/write.
- `wbs_sel_i`  in  4  byte selects; writes honour them per byte.
- `wbs_adr_i`  in  32  byte address; register index = `[3:2]`.
- `wbs_dat_i`  in  32  write data.
- `wbs_ack_o`  out  1  single-cycle acknowledge.
- `wbs_dat_o`  out  32  read data; 0 when not acking.
- `echo_i`  in  1  echo-detect flag from the receive datapath.
- `tx_o`  out  1  transducer drive square wave.
- `rx_en_o`  out  1  receive-chain enable, high only in LISTEN.
- `busy_o`  out  1  high in any state other than IDLE.
- `irq_o`  out  1  level interrupt.

## Operation
- Registers:
  - 0x0 CTRL: [0] START, write-1 pulse, reads 0. [1] CONT. [2] IRQ_EN. [3] ABORT, write-1 pulse, reads 0.
  - 0x4 PULSE: [15:0] TX_LEN in cycles. [23:16] TX_DIV, the tx_o half-period minus 1.
  - 0x8 TIMING: [15:0] BLANK in cycles. [31:16] WINDOW in cycles.
  - 0xC STATUS: [15:0] TOF (RO). [16] VALID (W1C). [17] TIMEOUT (W1C). [18] BUSY (RO).
- FSM states: IDLE, TX, BLANK, LISTEN, DONE.
  - IDLE→TX: on START write. START while busy is ignored.
  - TX: tx_o starts high and toggles every TX_DIV+1 cycles. Lasts max(TX_LEN,1) cycles, then goes to BLANK, or directly to LISTEN if BLANK=0. tx_o is forced 0 on exit.
  - BLANK: lasts BLANK cycles, then goes to LISTEN.
  - LISTEN: 16-bit counter cnt = 0 on the first LISTEN cycle, incrementing by 1 each cycle.
    - If the effective echo is 1 in a cycle: TOF←cnt, VALID←1, TIMEOUT←0, go to DONE.
    - Else if cnt == max(WINDOW,1)−1: TOF←16'hFFFF, TIMEOUT←1, VALID←0, go to DONE.
    - Echo takes priority when both occur in the same cycle.
  - DONE (1 cycle): if IRQ_EN, set the irq flag. Then go to TX if CONT=1, else IDLE.
- irq_o = irq flag & IRQ_EN.
  - The flag clears when software writes 1 to VALID or TIMEOUT.
  - If a set and a clear occur in the same cycle, set wins.
- ABORT:
  - From any state, goes to IDLE on the next edge and forces tx_o=0.
  - STATUS is unchanged.
  - ABORT and START written in the same cycle: ABORT wins.
- Clearing CONT mid-ping lets the current ping finish, then the FSM returns to IDLE.
- Register writes during a ping take effect at the next ping. Values are latched on entering TX.

## Timing
- Wishbone:
  - wbs_ack_o is asserted the cycle after a decoded `cyc&stb`, for exactly 1 cycle.
  - Back-to-back strobes ack every other cycle.
  - Write data is committed at the ack edge.
- START is acked at edge N; the FSM is in TX from edge N+1, so tx_o=1 in that cycle.
- Total ping length = TX_LEN + BLANK + (TOF+1 or WINDOW) + 1 (DONE).
- Reset values:
  - All outputs 0, state IDLE, all registers 0.
  - Assertion of reset mid-ping drops tx_o and rx_en_o immediately (asynchronously).

## Configuration
- `SONAR_SEQ_ECHO_SYNC_EN` defined:
  - echo_i passes through a 2-flop synchronizer before the FSM.
  - The effective echo lags echo_i by 2 cycles, and TOF reads 2 higher than with the macro undefined.
  - Synchronizer flops reset to 0.
- Macro undefined: echo_i is used directly; the source must already be synchronous to wb_clk_i.

## Test plan
- Reset, then read all 4 registers → all 0; irq_o=0, tx_o=0.
- Configuration:
  - TX_LEN=8, TX_DIV=1, BLANK=4, WINDOW=100, IRQ_EN=1, START.
  - Echo goes high 10 cycles after LISTEN entry (no sync).
  - Required response:
    - tx_o pattern 1,1,0,0,1,1,0,0.
    - rx_en_o high for 11 cycles.
    - STATUS = 0x0001_000A with BUSY=0.
    - irq_o high until VALID is written 1.
- WINDOW=20, no echo → TIMEOUT=1, TOF=0xFFFF. LISTEN lasts exactly 20 cycles.
- CONT=1 with 3 echoes → 3 back-to-back pings with no IDLE gap. Clear CONT → FSM idles after the current DONE.
- ABORT during BLANK → tx_o=0, busy_o=0 next cycle, STATUS unchanged. START together with ABORT → stays IDLE.
- With `SONAR_SEQ_ECHO_SYNC_EN`, repeat the first ping → TOF=12.
